// File: rtl/l15_req_port_arbiter.sv
// l15_req_port_arbiter
// Fixed-priority arbiter with starvation override. It merges NumPorts L1.5
// request ports onto a single registered request channel toward the L1.5.
//
// Ports:
//   clk_i         clock
//   reset_l       asynchronous active-low reset
//   arb_en_i      enables new grants (an in-flight request still completes)
//   req_valid_i   per-port request valid
//   req_data_i    per-port payload, port i at [i*ReqWidth +: ReqWidth]
//   req_ready_o   one-hot accept strobe, combinational
//   l15_val_o     request valid toward L1.5 (high in ISSUE)
//   l15_data_o    registered payload of the granted request
//   l15_portid_o  index of the granted port
//   l15_ack_i     L1.5 header acknowledge (ignored in IDLE)
//   starved_o     per-port flag, set when its wait counter is saturated
module l15_req_port_arbiter #(
  parameter int NumPorts = 6,
  parameter int ReqWidth = 128,
  parameter int StarveTh = 16,
  localparam int PidW = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_l,
  input  logic                         arb_en_i,
  input  logic [NumPorts-1:0]          req_valid_i,
  input  logic [NumPorts*ReqWidth-1:0] req_data_i,
  output logic [NumPorts-1:0]          req_ready_o,
  output logic                         l15_val_o,
  output logic [ReqWidth-1:0]          l15_data_o,
  output logic [PidW-1:0]              l15_portid_o,
  input  logic                         l15_ack_i,
  output logic [NumPorts-1:0]          starved_o
);

  localparam logic [7:0] StarveCnt = 8'(StarveTh);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_wait [NumPorts];
  logic [ReqWidth-1:0]   r_data;
  logic [PidW-1:0]       r_portid;

  logic                  w_accept_opp;
  logic                  w_grant;
  logic [NumPorts-1:0]   w_starved_valid;
  logic [NumPorts-1:0]   w_pri_mask;
  logic                  w_found;
  logic [PidW-1:0]       w_win_idx;
  logic [ReqWidth-1:0]   w_win_data;

  // A busy channel can take a new request in the same cycle its current
  // one is acknowledged, giving back-to-back issue.
  assign w_accept_opp = arb_en_i && ((r_state == IDLE) || l15_ack_i);

  // Starved requesters pre-empt plain priority; among either set the
  // lowest index wins.
  assign w_starved_valid = starved_o & req_valid_i;
  assign w_pri_mask      = (|w_starved_valid) ? w_starved_valid : req_valid_i;

  always_comb begin
    w_found    = 1'b0;
    w_win_idx  = '0;
    w_win_data = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (w_pri_mask[i]) begin
        w_found    = 1'b1;
        w_win_idx  = PidW'(i);
        w_win_data = req_data_i[i*ReqWidth +: ReqWidth];
      end
    end
  end

  // reset_l gates the strobe so no accept is signalled while in reset.
  assign w_grant = reset_l && w_accept_opp && w_found;

  always_comb begin
    req_ready_o = '0;
    if (w_grant) begin
      req_ready_o[w_win_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_next = ISSUE;
      ISSUE:   if (w_grant) w_state_next = ISSUE;
               else if (l15_ack_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload and port id only change on a grant, so they hold while the
  // L1.5 withholds its acknowledge.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      r_data   <= '0;
      r_portid <= '0;
    end else if (w_grant) begin
      r_data   <= w_win_data;
      r_portid <= w_win_idx;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumPorts; gi++) begin : g_wait
      // Counts cycles a valid request goes unserved, independent of
      // arb_en_i, and saturates at the starvation threshold.
      always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
          r_wait[gi] <= '0;
        end else if (!req_valid_i[gi] || req_ready_o[gi]) begin
          r_wait[gi] <= '0;
        end else if (r_wait[gi] != StarveCnt) begin
          r_wait[gi] <= r_wait[gi] + 8'd1;
        end
      end

      assign starved_o[gi] = (r_wait[gi] == StarveCnt);
    end
  endgenerate

  assign l15_val_o    = (r_state == ISSUE);
  assign l15_data_o   = r_data;
  assign l15_portid_o = r_portid;

endmodule

// File: tb/tb_l15_req_port_arbiter.sv
// Testbench for l15_req_port_arbiter: table of directed cycles, hand-written
// multi-cycle sequences, and a random stress run checked against a
// transaction-level reference model with a payload scoreboard.
module tb_l15_req_port_arbiter;

  localparam int NP = 6;
  localparam int RW = 32;
  localparam int TH = 4;
  localparam int PW = 3;

  logic              clk_i = 1'b0;
  logic              reset_l;
  logic              arb_en_i;
  logic [NP-1:0]     req_valid_i;
  logic [NP*RW-1:0]  req_data_i;
  logic [NP-1:0]     req_ready_o;
  logic              l15_val_o;
  logic [RW-1:0]     l15_data_o;
  logic [PW-1:0]     l15_portid_o;
  logic              l15_ack_i;
  logic [NP-1:0]     starved_o;

  always #5 clk_i = ~clk_i;

  l15_req_port_arbiter #(.NumPorts(NP), .ReqWidth(RW), .StarveTh(TH)) dut (
    .clk_i(clk_i), .reset_l(reset_l), .arb_en_i(arb_en_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .l15_val_o(l15_val_o),
    .l15_data_o(l15_data_o), .l15_portid_o(l15_portid_o),
    .l15_ack_i(l15_ack_i), .starved_o(starved_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: is a request outstanding, what it is, how long each
  // port has been waiting, and the order payloads were handed over.
  bit            m_busy;
  logic [RW-1:0] m_data;
  int            m_pid;
  int            m_cnt [NP];
  logic [RW-1:0] sb [$];

  typedef struct {
    logic [NP-1:0] v;
    bit            ack;
    bit            en;
    logic [NP-1:0] rdy;
    bit            val;
    int            pid;
  } vec_t;

  vec_t tbl [14];

  logic [NP-1:0] s_rdy;
  bit            s_val;
  int            s_pid;
  logic [RW-1:0] s_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [NP-1:0] v, input bit en, input bit ack);
    if (!(en && (!m_busy || ack))) return -1;
    for (int i = 0; i < NP; i++) if (v[i] && m_cnt[i] == TH) return i;
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_data = '0;
    m_pid  = 0;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    sb.delete();
  endtask

  // One clock cycle: drive at the falling edge, check settled outputs,
  // then advance the model across the rising edge.
  task automatic cycle(input logic [NP-1:0] v, input bit ack, input bit en);
    int w;
    logic [NP-1:0] exp_rdy;
    logic [NP-1:0] exp_st;
    logic [RW-1:0] pay [NP];
    logic [RW-1:0] front;
    @(negedge clk_i);
    req_valid_i = v;
    l15_ack_i   = ack;
    arb_en_i    = en;
    for (int i = 0; i < NP; i++) begin
      pay[i] = $urandom;
      req_data_i[i*RW +: RW] = pay[i];
    end
    #1;
    w = model_winner(v, en, ack);
    exp_rdy = (w < 0) ? '0 : (NP'(1) << w);
    for (int i = 0; i < NP; i++) exp_st[i] = (m_cnt[i] == TH);
    chk("ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("onehot0", 64'($onehot0(req_ready_o)), 64'(1));
    chk("val", 64'(l15_val_o), 64'(m_busy));
    chk("portid", 64'(l15_portid_o), 64'(m_pid));
    chk("data", 64'(l15_data_o), 64'(m_data));
    chk("starved", 64'(starved_o), 64'(exp_st));
    if (m_busy && ack) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 64'(1), 64'(0));
      end else begin
        front = sb.pop_front();
        chk("sb_order", 64'(l15_data_o), 64'(front));
      end
    end
    s_rdy  = req_ready_o;
    s_val  = l15_val_o;
    s_pid  = int'(l15_portid_o);
    s_data = l15_data_o;
    @(posedge clk_i);
    if (w >= 0) begin
      m_busy = 1;
      m_data = pay[w];
      m_pid  = w;
      sb.push_back(pay[w]);
    end else if (m_busy && ack) begin
      m_busy = 0;
    end
    for (int i = 0; i < NP; i++) begin
      if (!v[i] || w == i) m_cnt[i] = 0;
      else if (m_cnt[i] < TH) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // Assert reset between clock edges and check outputs clear at once.
  task automatic pulse_reset();
    @(negedge clk_i);
    req_valid_i = '1;
    arb_en_i    = 1'b1;
    #2;
    reset_l = 1'b0;
    #1;
    chk("rst_val", 64'(l15_val_o), 64'(0));
    chk("rst_starved", 64'(starved_o), 64'(0));
    chk("rst_pid", 64'(l15_portid_o), 64'(0));
    chk("rst_data", 64'(l15_data_o), 64'(0));
    chk("rst_ready", 64'(req_ready_o), 64'(0));
    model_reset();
    req_valid_i = '0;
    @(negedge clk_i);
    #2;
    reset_l = 1'b1;
  endtask

  logic [RW-1:0] held;

  initial begin
    tbl[0]  = '{6'b001010, 0, 1, 6'b000010, 0, 0};
    tbl[1]  = '{6'b001000, 0, 1, 6'b000000, 1, 1};
    tbl[2]  = '{6'b001000, 1, 1, 6'b001000, 1, 1};
    tbl[3]  = '{6'b000000, 1, 1, 6'b000000, 1, 3};
    tbl[4]  = '{6'b000000, 1, 1, 6'b000000, 0, 3};
    tbl[5]  = '{6'b100001, 0, 1, 6'b000001, 0, 3};
    tbl[6]  = '{6'b100001, 1, 1, 6'b000001, 1, 0};
    tbl[7]  = '{6'b100001, 1, 1, 6'b000001, 1, 0};
    tbl[8]  = '{6'b100001, 1, 1, 6'b000001, 1, 0};
    tbl[9]  = '{6'b100001, 1, 1, 6'b100000, 1, 0};
    tbl[10] = '{6'b000001, 1, 1, 6'b000001, 1, 5};
    tbl[11] = '{6'b000001, 1, 0, 6'b000000, 1, 0};
    tbl[12] = '{6'b000001, 0, 0, 6'b000000, 0, 0};
    tbl[13] = '{6'b000001, 0, 1, 6'b000001, 0, 0};

    reset_l     = 1'b0;
    arb_en_i    = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    l15_ack_i   = 1'b0;
    model_reset();
    #3;
    chk("init_val", 64'(l15_val_o), 64'(0));
    chk("init_ready", 64'(req_ready_o), 64'(0));
    chk("init_starved", 64'(starved_o), 64'(0));
    #9;
    reset_l = 1'b1;

    // Directed cycles: priority, hold, idle ack, starvation, arb_en.
    for (int k = 0; k < 14; k++) begin
      cycle(tbl[k].v, tbl[k].ack, tbl[k].en);
      chk("tbl_ready", 64'(s_rdy), 64'(tbl[k].rdy));
      chk("tbl_val", 64'(s_val), 64'(tbl[k].val));
      chk("tbl_pid", 64'(s_pid), 64'(tbl[k].pid));
      $display("vec %0d: valid=%b ack=%0d en=%0d ready=%b val=%0d pid=%0d",
               k, tbl[k].v, tbl[k].ack, tbl[k].en, s_rdy, s_val, s_pid);
    end

    // Drain, then hold for 5 unacked cycles and hand off back to back.
    cycle(6'b000000, 1, 1);
    cycle(6'b000010, 0, 1);
    cycle(6'b001000, 0, 1);
    held = s_data;
    chk("hold_pid0", 64'(s_pid), 64'(1));
    for (int k = 0; k < 4; k++) begin
      cycle(6'b001000, 0, 1);
      chk("hold_data", 64'(s_data), 64'(held));
      chk("hold_pid", 64'(s_pid), 64'(1));
    end
    cycle(6'b001000, 1, 1);
    chk("b2b_ready", 64'(s_rdy), 64'(6'b001000));
    cycle(6'b000000, 1, 1);
    chk("b2b_val", 64'(s_val), 64'(1));
    chk("b2b_pid", 64'(s_pid), 64'(3));
    $display("seq hold/b2b done");

    // arb_en_i low during ISSUE: completes on ack, no new grants.
    cycle(6'b000100, 0, 1);
    cycle(6'b000100, 1, 0);
    chk("dis_ready0", 64'(s_rdy), 64'(0));
    cycle(6'b000100, 0, 0);
    chk("dis_val", 64'(s_val), 64'(0));
    chk("dis_ready1", 64'(s_rdy), 64'(0));
    cycle(6'b000100, 0, 1);
    chk("en_ready", 64'(s_rdy), 64'(6'b000100));
    $display("seq arb_en done");

    // Reset while a request is outstanding.
    cycle(6'b000000, 0, 1);
    chk("pre_rst_val", 64'(s_val), 64'(1));
    pulse_reset();
    $display("seq reset done");

    // Random stress.
    for (int k = 0; k < 10000; k++) begin
      cycle(NP'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
    end
    $display("random stress done, %0d in flight", sb.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l15_req_port_arbiter.md
L15_REQ_PORT_ARBITER -- requirements
Module: l15_req_port_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 6, number of requester ports; port 0 is highest priority.
REQ-002 SHALL have parameter ReqWidth, default 128, width of one packed L1.5 request.
REQ-003 SHALL have parameter StarveTh, default 16, wait cycles before a port is marked starved; legal range 1..255.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port reset_l, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port arb_en_i, input, 1, enables new grants; low blocks new acceptance only.
REQ-007 SHALL have port req_valid_i, input, NumPorts, per-port request valid.
REQ-008 SHALL have port req_data_i, input, NumPorts*ReqWidth, per-port request payload; port i occupies bits [i*ReqWidth +: ReqWidth].
REQ-009 SHALL have port req_ready_o, output, NumPorts, one-hot accept strobe.
REQ-010 SHALL have port l15_val_o, output, 1, request valid toward L1.5.
REQ-011 SHALL have port l15_data_o, output, ReqWidth, registered payload of the granted request.
REQ-012 SHALL have port l15_portid_o, output, clog2(NumPorts), index of the granted port.
REQ-013 SHALL have port l15_ack_i, input, 1, L1.5 header acknowledge.
REQ-014 SHALL have port starved_o, output, NumPorts, per-port starved flag for PMU/debug.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (l15_val_o=0) and ISSUE (l15_val_o=1).
REQ-016 An accept opportunity SHALL exist when arb_en_i=1 and either (state=IDLE) or (state=ISSUE and l15_ack_i=1).
REQ-017 On an accept opportunity with any req_valid_i set, SHALL pick a winner, assert req_ready_o for the winner only, in the same cycle (combinational from req_valid_i, state, counters).
REQ-018 Winner selection: lowest-index starved port with valid high; if none, lowest-index port with valid high.
REQ-019 On accept, SHALL register req_data_i slice and index into l15_data_o and l15_portid_o, and enter ISSUE the next cycle; one-cycle latency from accept to l15_val_o.
REQ-020 In ISSUE without l15_ack_i, l15_val_o, l15_data_o and l15_portid_o SHALL hold stable.
REQ-021 In ISSUE with l15_ack_i and no accept, SHALL return to IDLE next cycle.
REQ-022 In ISSUE with l15_ack_i and an accept (back-to-back), SHALL stay ISSUE with new payload next cycle; sustained throughput one request per cycle.
REQ-023 l15_ack_i in IDLE SHALL be ignored.
REQ-024 Per-port wait counter, 8 bits: increments by 1 when valid high and port not accepted; saturates at StarveTh; clears to 0 on accept or when valid low.
REQ-025 starved_o[i] SHALL equal (counter[i]==StarveTh).
REQ-026 arb_en_i=0 SHALL not abort an in-flight ISSUE; outstanding request completes on ack; counters keep counting.
REQ-027 req_ready_o SHALL never be asserted for a port whose req_valid_i is low, and at most one bit SHALL be set per cycle.

Reset
REQ-028 reset_l low SHALL asynchronously force state=IDLE, l15_val_o=0, l15_data_o=0, l15_portid_o=0, all counters=0, starved_o=0.
REQ-029 req_ready_o SHALL be 0 while reset_l is low; reset mid-ISSUE drops the request without ack.
REQ-030 First accept SHALL be possible on the first rising edge after reset_l deasserts.

Verification
REQ-031 Ports 1 and 3 valid in IDLE, arb_en_i=1 -> req_ready_o=6'b000010, next cycle l15_val_o=1, l15_portid_o=1.
REQ-032 ISSUE port 1, ack withheld 5 cycles -> l15_data_o and l15_portid_o stable 5 cycles; on ack with port 3 valid -> portid=3 next cycle, l15_val_o continuous.
REQ-033 StarveTh=4, port 0 and port 5 valid continuously, ack every cycle -> port 5 counter reaches 4, starved_o[5]=1, port 5 granted next opportunity, counter clears to 0.
REQ-034 arb_en_i=0 while ISSUE -> ack returns to IDLE, req_ready_o stays 0 until arb_en_i=1.
REQ-035 reset_l pulsed low mid-ISSUE -> l15_val_o=0 immediately without clock edge, starved_o=0, portid=0.
REQ-036 Random valid/ack stress 10k cycles -> req_ready_o one-hot-or-zero, every accepted payload appears exactly once on l15_data_o in accept order.
